// File: rtl/conv_pkg.sv
// Shared convolutional-code constants, the frame FSM state type and a parity helper.
// The defaults are also used by the Viterbi decoder, so both sides agree on trellis and symbol bit order.
package conv_pkg;

    localparam int CONV_KMAX = 16;
    localparam int CONV_K = 3;
    localparam logic [CONV_K-1:0] CONV_G1 = 3'b111;
    localparam logic [CONV_K-1:0] CONV_G0 = 3'b101;

    typedef enum logic {
        DATA = 1'b0,
        TAIL = 1'b1
    } conv_state_e;

    // Callers zero-extend w and g to CONV_KMAX; the MSB of the code's own width taps the newest bit.
    function automatic logic conv_parity(input logic [CONV_KMAX-1:0] w,
                                         input logic [CONV_KMAX-1:0] g);
        return ^(w & g);
    endfunction

endpackage

// File: rtl/conv_frame_encoder_if.sv
// Bit-source / symbol-sink signal bundle of the frame encoder.
// Modport master: source side. Modport slave: encoder side.
interface conv_frame_encoder_if;

    logic       enable_i;
    logic       d_in;
    logic       ready_o;
    logic       valid_o;
    logic [1:0] d_out;
    logic       last_o;
    logic [1:0] erase_o;
    logic       overflow_o;

    modport master (
        output enable_i, d_in,
        input  ready_o, valid_o, d_out, last_o, erase_o, overflow_o
    );

    modport slave (
        input  enable_i, d_in,
        output ready_o, valid_o, d_out, last_o, erase_o, overflow_o
    );

endinterface

// File: rtl/conv_shift_core.sv
// Encoder memory and parity generation: sym_o is the symbol for bit_i given the current memory.
// The memory shifts only when shift_i is high.
module conv_shift_core
    import conv_pkg::*;
#(
    parameter int             K  = CONV_K,
    parameter logic [K-1:0]   G1 = CONV_G1,
    parameter logic [K-1:0]   G0 = CONV_G0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       shift_i,
    input  logic       bit_i,
    output logic [1:0] sym_o
);

    logic [K-2:0] sr_q;
    logic [K-1:0] w;

    // sr_q[K-2] is the most recent past bit, so the new bit enters at the top.
    assign w = {bit_i, sr_q};

    assign sym_o = {conv_parity(CONV_KMAX'(w), CONV_KMAX'(G1)),
                    conv_parity(CONV_KMAX'(w), CONV_KMAX'(G0))};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else if (shift_i) begin
            sr_q <= w[K-1:1];
        end
    end

endmodule

// File: rtl/conv_frame_encoder.sv
// Rate-1/2 convolutional encoder with per-frame zero-tail termination.
// Optional rate-2/3 puncturing is built when CONV_PUNCTURE_EN is defined.
//
// state | meaning
// ------+-----------------------------------------------------------
// DATA  | accept enabled bits, one symbol each, count up to FRAME_LEN
// TAIL  | encode K-1 zero bits to return the trellis to state 0
module conv_frame_encoder
    import conv_pkg::*;
#(
    parameter int           K         = CONV_K,
    parameter logic [K-1:0] G1        = K'(CONV_G1),
    parameter logic [K-1:0] G0        = K'(CONV_G0),
    parameter int           FRAME_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    conv_frame_encoder_if.slave  bus
);

    localparam int CW = $clog2(FRAME_LEN + 1);
    localparam int TW = (K > 2) ? $clog2(K - 1) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(FRAME_LEN - 1);
    localparam logic [TW-1:0] TAIL_LAST = TW'(K - 2);

    if (K < 2) begin : g_bad_k
        $error("conv_frame_encoder: K must be at least 2, a zero tail needs K-1 >= 1 symbols");
    end
    if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_len
        $error("conv_frame_encoder: FRAME_LEN must be within 1..65535");
    end

    conv_state_e   state_q;
    logic [CW-1:0] cnt_q;
    logic [TW-1:0] tail_q;
    logic          valid_q;
    logic          last_q;
    logic          ovf_q;
    logic [1:0]    d_q;
    logic [1:0]    sym;
    logic [1:0]    sym_d;
    logic          in_data;
    logic          shift;
    logic          tail_end;

    assign in_data  = (state_q == DATA);
    assign shift    = in_data ? bus.enable_i : 1'b1;
    assign tail_end = (state_q == TAIL) && (tail_q == TAIL_LAST);

    conv_shift_core #(
        .K  (K),
        .G1 (G1),
        .G0 (G0)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .shift_i (shift),
        .bit_i   (in_data & bus.d_in),
        .sym_o   (sym)
    );

`ifdef CONV_PUNCTURE_EN
    logic       idx_q;
    logic [1:0] er_q;
    logic [1:0] er_d;

    // Odd symbols of the frame lose their G0 bit; the index restarts after each tail.
    always_comb begin
        sym_d = sym;
        er_d  = 2'b00;
        if (idx_q) begin
            sym_d[0] = 1'b0;
            er_d     = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q <= 1'b0;
            er_q  <= 2'b00;
        end else if (shift) begin
            idx_q <= tail_end ? 1'b0 : ~idx_q;
            er_q  <= er_d;
        end
    end

    assign bus.erase_o = er_q;
`else
    assign sym_d       = sym;
    assign bus.erase_o = 2'b00;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= DATA;
            cnt_q   <= '0;
            tail_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            ovf_q   <= 1'b0;
            d_q     <= 2'b00;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            if (!in_data && bus.enable_i) begin
                ovf_q <= 1'b1;
            end
            case (state_q)
                DATA: begin
                    if (bus.enable_i) begin
                        valid_q <= 1'b1;
                        d_q     <= sym_d;
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            state_q <= TAIL;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                end
                TAIL: begin
                    valid_q <= 1'b1;
                    d_q     <= sym_d;
                    if (tail_end) begin
                        tail_q  <= '0;
                        last_q  <= 1'b1;
                        state_q <= DATA;
                    end else begin
                        tail_q <= tail_q + TW'(1);
                    end
                end
                default: state_q <= DATA;
            endcase
        end
    end

    assign bus.ready_o    = in_data;
    assign bus.valid_o    = valid_q;
    assign bus.d_out      = d_q;
    assign bus.last_o     = last_q;
    assign bus.overflow_o = ovf_q;

endmodule

// File: doc/conv_frame_encoder.md
Name: conv_frame_encoder

Overview:
- Rate-1/2 feedforward convolutional encoder with frame-based zero-tail termination.
- The transmit-side counterpart of the Viterbi decoder: it accepts one information bit per enabled cycle and emits one 2-bit symbol per data bit.
- After each frame it appends K-1 flush symbols so every frame ends in state 0, which is what the decoder's traceback requires.
- Sits between the bit source and the channel or error-injection stage in the tx/rx harness.

Parameters:
- K, 3: constraint length; the shift register holds K-1 past bits.
- G1, 3'b111: generator polynomial for d_out[1], K bits wide. The MSB taps the newest bit.
- G0, 3'b101: generator polynomial for d_out[0], K bits wide. The MSB taps the newest bit.
- FRAME_LEN, 16: information bits per frame. Legal range is 1..65535.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- enable_i  input  1  d_in is valid this cycle.
- d_in  input  1  information bit.
- ready_o  output  1  encoder accepts data this cycle.
- valid_o  output  1  d_out holds a valid symbol.
- d_out  output  2  encoded symbol, {G1 parity, G0 parity}.
- last_o  output  1  marks the final tail symbol of the frame.
- erase_o  output  2  puncture mask; a 1 means that bit is erased.
- overflow_o  output  1  sticky; enable_i was asserted while ready_o was low.

Behaviour:
- Reset values: all outputs 0, shift register sr = 0, frame counter = 0, state = DATA. Reset takes effect asynchronously at any point, including mid-frame or mid-tail. The partial frame is discarded with no tail emitted.
- ready_o is combinational: 1 in DATA, 0 in TAIL.
- Encoding:
  - Let w = {b, sr[K-2:0]}, where b is the incoming bit and sr[K-2] is the most recent past bit.
  - d_out[1] = ^(w & G1); d_out[0] = ^(w & G0).
  - sr <= w[K-1:1] on every symbol produced.
- Latency: 1 cycle. The symbol for a bit accepted at edge n is visible on d_out/valid_o after edge n+1.
- All outputs are registered. Between symbols, d_out holds its last value and valid_o = 0.
- State machine:
  - DATA:
    - enable_i=1 accepts d_in, emits a symbol and increments cnt.
    - When the FRAME_LEN-th bit is accepted, go to TAIL with cnt cleared.
    - enable_i=0: no state change, valid_o=0. Gaps are allowed anywhere in a frame.
  - TAIL:
    - Each cycle, encode b=0 and emit a symbol with valid_o=1, regardless of enable_i.
    - Runs K-1 cycles. On the final one, last_o=1, then return to DATA.
    - sr is 0 on exit.
  - K=1 (no tail) is illegal; flag it with an elaboration-time assertion.
- enable_i=1 during TAIL: the bit is dropped and overflow_o is set. overflow_o clears only on reset.
- The cycle that accepts the FRAME_LEN-th bit and the first tail cycle are distinct. There is no bubble between them.
- Counter width is $clog2(FRAME_LEN+1) bits. cnt never wraps because it is cleared on the DATA->TAIL transition.

Optional Feature:
- Macro: CONV_PUNCTURE_EN.
- When defined: rate-2/3 puncturing, period P = [11;10]. A symbol index toggles on every valid symbol, including tail symbols, and resets to 0 at frame start.
  - Even symbols: erase_o=2'b00.
  - Odd symbols: erase_o=2'b01 and d_out[0] forced to 0.
- When undefined: erase_o is tied to 2'b00 and d_out is unmodified.

Decomposition:
- Package conv_pkg holds:
  - the state enum typedef {DATA, TAIL};
  - default constants CONV_K, CONV_G1 and CONV_G0, shared with the Viterbi decoder so both agree on trellis and symbol bit order;
  - a function conv_parity(w, g).
- One natural sub-module, conv_shift_core: shift register plus parity generation.
- The frame/tail FSM, counters and puncture logic stay in the top module.

Test Plan:
- Default params, FRAME_LEN=4, bits 1,0,1,1 on consecutive cycles:
  - d_out sequence 11,10,00,01 then tail 01,11;
  - valid_o high for 6 consecutive cycles;
  - last_o only on the 6th symbol.
- Same frame with enable_i gaps of 2 idle cycles between bits:
  - identical symbol sequence;
  - valid_o low during gaps;
  - d_out held.
- enable_i=1 with d_in=1 during both tail cycles: tail symbols still 01,11, overflow_o=1 and stays 1 until reset.
- rst asserted low after the 2nd data bit: outputs 0 immediately. A new frame of 1,0,1,1 then reproduces 11,10,00,01,01,11, confirming sr was cleared.
- Two back-to-back frames, all-ones then all-zeros:
  - second frame's first symbol is computed from sr=0;
  - all-zero frame emits only 00 symbols, including its tail.
- With CONV_PUNCTURE_EN, frame 1,0,1,1: d_out 11,10,00,00,01,10 and erase_o 00,01,00,01,00,01.
